// File: rtl/spi_flash_responder.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_responder
// Summary  : SPI mode-0 flash read responder (0x03 read) backed by a
//            synchronous byte memory. Define SPIFLASH_JEDEC_ID_EN to build
//            the 0x9F JEDEC ID response; otherwise 0x9F is unsupported.
// Revision : 1.0  initial release
// ============================================================================
module spi_flash_responder #(
  parameter int          ADDR_W   = 10,
  parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              spi_csb,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              cmd_err
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_IGNORE = 3'd5;
`ifdef SPIFLASH_JEDEC_ID_EN
  localparam logic [2:0] ST_ID     = 3'd4;
`endif

  logic              r_csb_meta, r_csb_sync, r_csb_d;
  logic              r_sclk_meta, r_sclk_sync, r_sclk_d;
  logic              r_mosi_meta, r_mosi_sync;
  logic [2:0]        r_state;
  logic [4:0]        r_bit_cnt;
  logic [23:0]       r_shift;
  logic              r_miso;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [1:0]        r_load_pend;
  logic              r_cmd_err;
  logic              r_busy;
  logic [1:0]        r_flush;
  logic              r_armed;

  logic              w_rise, w_fall, w_csb_fall, w_tx_state;
  logic [23:0]       w_shift_in;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_csb_meta  <= 1'b1;
      r_csb_sync  <= 1'b1;
      r_csb_d     <= 1'b1;
      r_sclk_meta <= 1'b0;
      r_sclk_sync <= 1'b0;
      r_sclk_d    <= 1'b0;
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
    end else begin
      r_csb_meta  <= spi_csb;
      r_csb_sync  <= r_csb_meta;
      r_csb_d     <= r_csb_sync;
      r_sclk_meta <= spi_sclk;
      r_sclk_sync <= r_sclk_meta;
      r_sclk_d    <= r_sclk_sync;
      r_mosi_meta <= spi_mosi;
      r_mosi_sync <= r_mosi_meta;
    end
  end

  assign w_rise     = r_sclk_sync & ~r_sclk_d;
  assign w_fall     = ~r_sclk_sync & r_sclk_d;
  assign w_csb_fall = ~r_csb_sync & r_csb_d;
  assign w_shift_in = {r_shift[22:0], r_mosi_sync};

`ifdef SPIFLASH_JEDEC_ID_EN
  assign w_tx_state = (r_state == ST_DATA) || (r_state == ST_ID);
`else
  assign w_tx_state = (r_state == ST_DATA);
  logic w_unused_jedec;
  assign w_unused_jedec = ^JEDEC_ID;
`endif

  // Arming waits for the synchronizers to flush and csb to be seen high, so a
  // reset released while csb is already low cannot start a transaction.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= 5'd0;
      r_shift     <= 24'd0;
      r_miso      <= 1'b0;
      r_mem_addr  <= '0;
      r_load_pend <= 2'd0;
      r_cmd_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_flush     <= 2'd0;
      r_armed     <= 1'b0;
    end else begin
      r_cmd_err <= 1'b0;
      r_busy    <= ~r_csb_sync;
      if (r_flush != 2'd3)
        r_flush <= r_flush + 2'd1;
      if ((r_flush == 2'd3) && r_csb_sync)
        r_armed <= 1'b1;
      if (r_load_pend != 2'd0)
        r_load_pend <= r_load_pend - 2'd1;

      if ((r_state != ST_IDLE) && r_csb_sync) begin
        r_state     <= ST_IDLE;
        r_miso      <= 1'b0;
        r_load_pend <= 2'd0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_csb_fall && r_armed) begin
              r_state   <= ST_CMD;
              r_bit_cnt <= 5'd0;
              r_shift   <= 24'd0;
              r_miso    <= 1'b0;
            end
          end
          ST_CMD: begin
            if (w_rise) begin
              r_shift   <= w_shift_in;
              r_bit_cnt <= r_bit_cnt + 5'd1;
              if (r_bit_cnt == 5'd7) begin
                r_bit_cnt <= 5'd0;
                case (w_shift_in[7:0])
                  8'h03: r_state <= ST_ADDR;
`ifdef SPIFLASH_JEDEC_ID_EN
                  8'h9F: begin
                    r_state <= ST_ID;
                    r_shift <= JEDEC_ID;
                  end
`endif
                  8'hAB, 8'hFF: r_state <= ST_IGNORE;
                  default: begin
                    r_state   <= ST_IGNORE;
                    r_cmd_err <= 1'b1;
                  end
                endcase
              end
            end
          end
          ST_ADDR: begin
            if (w_rise) begin
              r_shift   <= w_shift_in;
              r_bit_cnt <= r_bit_cnt + 5'd1;
              if (r_bit_cnt == 5'd23) begin
                r_bit_cnt   <= 5'd0;
                r_mem_addr  <= w_shift_in[ADDR_W-1:0];
                r_load_pend <= 2'd2;
                r_state     <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            // Memory answers one cycle after the address, so load on the second.
            if (r_load_pend == 2'd1) begin
              r_shift <= {mem_rdata, 16'd0};
            end else if (w_fall) begin
              r_miso    <= r_shift[23];
              r_shift   <= {r_shift[22:0], 1'b0};
              r_bit_cnt <= r_bit_cnt + 5'd1;
              if (r_bit_cnt == 5'd7) begin
                r_bit_cnt   <= 5'd0;
                r_mem_addr  <= r_mem_addr + ADDR_W'(1);
                r_load_pend <= 2'd2;
              end
            end
          end
`ifdef SPIFLASH_JEDEC_ID_EN
          ST_ID: begin
            if (w_fall) begin
              r_miso  <= r_shift[23];
              r_shift <= {r_shift[22:0], 1'b0};
            end
          end
`endif
          ST_IGNORE: ;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign spi_miso_oe = w_tx_state & ~r_csb_sync;
  assign spi_miso    = r_miso & spi_miso_oe;
  assign mem_addr    = r_mem_addr;
  assign busy        = r_busy;
  assign cmd_err     = r_cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_responder.sv
`default_nettype none
// Self-checking bench for spi_flash_responder: SPI master tasks driving reads,
// ID, abort, bad-opcode and reset cases against a byte-memory reference.
module tb_spi_flash_responder;

  localparam int ADDR_W   = 10;
  localparam int MEM_SIZE = 1 << ADDR_W;

  logic              clk  = 1'b0;
  logic              rst  = 1'b1;
  logic              csb  = 1'b1;
  logic              sclk = 1'b0;
  logic              mosi = 1'b0;
  logic              miso, oe, busy, cmd_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic [7:0]        mem [0:MEM_SIZE-1];

  int n_checks   = 0;
  int n_fail     = 0;
  int err_pulses = 0;
  int half       = 6;

  spi_flash_responder #(.ADDR_W(ADDR_W), .JEDEC_ID(24'hEF4016)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .spi_csb    (csb),
    .spi_sclk   (sclk),
    .spi_mosi   (mosi),
    .spi_miso   (miso),
    .spi_miso_oe(oe),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .cmd_err    (cmd_err)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data valid one cycle after the address.
  always @(posedge clk) mem_rdata <= mem[mem_addr];

  always @(posedge clk) if (cmd_err === 1'b1) err_pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, output logic r, output logic o);
    mosi = b;
    wait_clks(half);
    r = miso;
    o = oe;
    sclk = 1'b1;
    wait_clks(half);
    sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx,
                          output logic oe_all, output logic oe_any);
    logic r, o;
    oe_all = 1'b1;
    oe_any = 1'b0;
    rx     = 8'd0;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], r, o);
      rx[i]  = r;
      oe_all = oe_all & o;
      oe_any = oe_any | o;
    end
  endtask

  task automatic cs_start();
    csb = 1'b0;
    wait_clks(6);
  endtask

  task automatic cs_end();
    wait_clks(half);
    csb = 1'b1;
    wait_clks(8);
  endtask

  // Sends 03 + 24-bit address, clocks n bytes, checks each against the memory
  // model; got packs the received bytes, first byte most significant.
  task automatic do_read(input string tag, input logic [23:0] a, input int n,
                         output logic [31:0] got);
    logic [7:0] rx;
    logic       oa, oy, hdr_oe, dat_oe;
    int         base, idx;
    hdr_oe = 1'b0;
    dat_oe = 1'b1;
    got    = 32'd0;
    base   = int'(a[ADDR_W-1:0]);
    cs_start();
    spi_byte(8'h03,     rx, oa, oy); hdr_oe = hdr_oe | oy;
    spi_byte(a[23:16],  rx, oa, oy); hdr_oe = hdr_oe | oy;
    spi_byte(a[15:8],   rx, oa, oy); hdr_oe = hdr_oe | oy;
    spi_byte(a[7:0],    rx, oa, oy); hdr_oe = hdr_oe | oy;
    check({tag, "_hdr_oe"}, 32'(hdr_oe), 32'd0);
    for (int k = 0; k < n; k++) begin
      spi_byte(8'($urandom), rx, oa, oy);
      idx = (base + k) % MEM_SIZE;
      check($sformatf("%s_d%0d", tag, k), 32'(rx), 32'(mem[idx]));
      dat_oe = dat_oe & oa;
      got = {got[23:0], rx};
    end
    check({tag, "_data_oe"}, 32'(dat_oe), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    cs_end();
    check({tag, "_idle_oe"}, 32'(oe), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  // Sends an opcode and clocks n extra bytes.
  task automatic do_cmd(input logic [7:0] op, input int n, output logic [31:0] got,
                        output logic any_oe, output logic all_oe);
    logic [7:0] rx;
    logic       oa, oy;
    got    = 32'd0;
    any_oe = 1'b0;
    all_oe = 1'b1;
    cs_start();
    spi_byte(op, rx, oa, oy);
    any_oe = any_oe | oy;
    for (int k = 0; k < n; k++) begin
      spi_byte(8'($urandom), rx, oa, oy);
      got    = {got[23:0], rx};
      any_oe = any_oe | oy;
      all_oe = all_oe & oa;
    end
    cs_end();
  endtask

  initial begin
    logic [31:0] got;
    logic        any_oe, all_oe, r, o;
    logic [7:0]  rx;
    int          e0;

    for (int i = 0; i < MEM_SIZE; i++) mem[i] = 8'(i);

    // Power-on reset state
    wait_clks(5);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_oe", 32'(oe), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(cmd_err), 32'd0);
    rst = 1'b0;
    wait_clks(10);

    // Basic read and wrap past the top of the address space
    half = $urandom_range(6, 10);
    do_read("rd10", 24'h000010, 4, got);
    check("rd10_bytes", got, 32'h10111213);
    half = $urandom_range(6, 10);
    do_read("wrap", 24'h0003FE, 4, got);
    check("wrap_bytes", got, 32'hFEFF0001);

    // JEDEC ID
    e0 = err_pulses;
    do_cmd(8'h9F, 4, got, any_oe, all_oe);
`ifdef SPIFLASH_JEDEC_ID_EN
    check("id_bytes", got, 32'hEF401600);
    check("id_oe", 32'(all_oe), 32'd1);
    check("id_err", 32'(err_pulses - e0), 32'd0);
`else
    check("id_err", 32'(err_pulses - e0), 32'd1);
    check("id_oe", 32'(any_oe), 32'd0);
    check("id_miso", got, 32'd0);
`endif

    // Abort after 3 data bits, then a clean read
    half = 7;
    cs_start();
    spi_byte(8'h03, rx, all_oe, any_oe);
    spi_byte(8'h00, rx, all_oe, any_oe);
    spi_byte(8'h00, rx, all_oe, any_oe);
    spi_byte(8'h20, rx, all_oe, any_oe);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, r, o);
    cs_end();
    do_read("abort", 24'h000040, 2, got);
    check("abort_bytes", got, 32'h00004041);

    // Unsupported opcode and silently ignored opcodes
    e0 = err_pulses;
    do_cmd(8'h5A, 2, got, any_oe, all_oe);
    check("bad_err", 32'(err_pulses - e0), 32'd1);
    check("bad_oe", 32'(any_oe), 32'd0);
    check("bad_miso", got, 32'd0);
    e0 = err_pulses;
    do_cmd(8'hAB, 1, got, any_oe, all_oe);
    do_cmd(8'hFF, 1, got, any_oe, all_oe);
    check("silent_err", 32'(err_pulses - e0), 32'd0);
    check("silent_oe", 32'(any_oe), 32'd0);
    do_read("after_bad", 24'h000123, 2, got);
    check("after_bad_bytes", got, 32'h00002324);

    // Random memory contents, addresses (upper bits ignored), lengths, rates
    for (int i = 0; i < MEM_SIZE; i++) mem[i] = 8'($urandom);
    for (int t = 0; t < 5; t++) begin
      half = $urandom_range(6, 10);
      do_read($sformatf("rnd%0d", t), 24'($urandom), $urandom_range(1, 4), got);
    end

    // Reset mid-DATA with csb held low
    half = 6;
    cs_start();
    spi_byte(8'h03, rx, all_oe, any_oe);
    spi_byte(8'h00, rx, all_oe, any_oe);
    spi_byte(8'h01, rx, all_oe, any_oe);
    spi_byte(8'h00, rx, all_oe, any_oe);
    spi_byte(8'h00, rx, all_oe, any_oe);
    for (int i = 0; i < 3; i++) spi_bit(1'b1, r, o);
    check("mid_oe", 32'(oe), 32'd1);
    rst = 1'b1;
    #1;
    check("mrst_miso", 32'(miso), 32'd0);
    check("mrst_oe", 32'(oe), 32'd0);
    check("mrst_addr", 32'(mem_addr), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_err", 32'(cmd_err), 32'd0);
    wait_clks(3);
    rst = 1'b0;
    wait_clks(4);
    e0 = err_pulses;
    any_oe = 1'b0;
    got = 32'd0;
    spi_byte(8'h03, rx, all_oe, o); any_oe = any_oe | o; got = got | 32'(rx);
    spi_byte(8'h5A, rx, all_oe, o); any_oe = any_oe | o; got = got | 32'(rx);
    spi_byte(8'h00, rx, all_oe, o); any_oe = any_oe | o; got = got | 32'(rx);
    check("post_rst_oe", 32'(any_oe), 32'd0);
    check("post_rst_miso", got, 32'd0);
    check("post_rst_addr", 32'(mem_addr), 32'd0);
    check("post_rst_err", 32'(err_pulses - e0), 32'd0);
    cs_end();
    do_read("post_rst_rd", 24'h0002F0, 3, got);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_flash_responder.md
SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

Interface
REQ-001 Parameter ADDR_W, default 10: width of the byte address presented to the backing memory.
REQ-002 Parameter JEDEC_ID, default 24'hEF4016: ID bytes returned MSB first for command 0x9F.
REQ-003 Ports, clock and reset first (name direction width meaning):
- wb_clk_i  in  1  single system clock; all logic runs on rising edge.
- wb_rst_i  in  1  asynchronous, active-high reset.
- spi_csb  in  1  chip select from initiator, active low, asynchronous to wb_clk_i.
- spi_sclk  in  1  SPI clock (mode 0), asynchronous.
- spi_mosi  in  1  initiator-to-responder data (flash_io0).
- spi_miso  out  1  responder-to-initiator data (flash_io1).
- spi_miso_oe  out  1  output enable for spi_miso pad.
- mem_addr  out  ADDR_W  byte address to synchronous ROM/RAM.
- mem_rdata  in  8  byte from memory, valid exactly one cycle after mem_addr changes.
- busy  out  1  high while a transaction is in progress (synced csb low).
- cmd_err  out  1  one-cycle pulse when an unsupported opcode completes.

Function
REQ-004 spi_csb, spi_sclk, spi_mosi shall pass through two-flop synchronizers; edge detection uses the synchronized sclk; supported sclk frequency <= wb_clk_i/8.
REQ-005 Mode 0: MOSI sampled on detected sclk rising edge, MSB first; MISO updated on detected sclk falling edge.
REQ-006 States: IDLE, CMD, ADDR, DATA, ID, IGNORE.
REQ-007 IDLE -> CMD when synced csb falls; bit counter cleared.
REQ-008 CMD: after 8 rising edges, opcode 0x03 -> ADDR, 0x9F -> ID, 0xAB or 0xFF -> IGNORE silently, any other -> IGNORE with cmd_err pulsed the next cycle.
REQ-009 ADDR: shifts 24 address bits; on 24th rising edge mem_addr <= addr[ADDR_W-1:0] and DATA entered; upper address bits ignored.
REQ-010 DATA: byte shift register loads mem_rdata two cycles after mem_addr update (before the first falling edge); bit 7 driven on first falling edge, then one bit per falling edge.
REQ-011 DATA: after each 8th falling edge, mem_addr increments by 1 modulo 2^ADDR_W (wraps to 0 after all-ones) and the next byte is loaded; reads continue indefinitely.
REQ-012 ID: returns JEDEC_ID[23:16], [15:8], [7:0] in order; after third byte spi_miso holds 0.
REQ-013 spi_miso_oe high only in DATA or ID with synced csb low; spi_miso = 0 whenever spi_miso_oe is low.
REQ-014 Synced csb rising in any state forces IDLE on the next cycle, discarding partial bytes/addresses; spi_miso_oe low the same cycle.
REQ-015 csb rise and sclk edge detected in the same cycle: csb rise wins, edge ignored.
REQ-016 busy = synced csb low, registered.

Reset
REQ-017 wb_rst_i high asynchronously forces: state IDLE, spi_miso 0, spi_miso_oe 0, mem_addr 0, busy 0, cmd_err 0, synchronizer flops to idle levels (csb 1, sclk 0, mosi 0), all counters and shift registers 0.
REQ-018 Reset release mid-transaction (csb already low): block stays IDLE until csb is seen high then falls again.

Configuration
REQ-019 Macro SPIFLASH_JEDEC_ID_EN: when defined, 0x9F behaves per REQ-012; when undefined, the ID state is not built and 0x9F is treated as unsupported (IGNORE, cmd_err pulsed).

Verification
REQ-020 Memory byte[i]=i&8'hFF; send 03 00 00 10, clock 4 bytes -> MISO returns 10 11 12 13, spi_miso_oe high only during data phase.
REQ-021 ADDR_W=10; send 03 00 03 FE, clock 4 bytes -> FE FF 00 01 (wrap to 0).
REQ-022 With SPIFLASH_JEDEC_ID_EN: send 9F, clock 4 bytes -> EF 40 16 00; without it -> cmd_err one pulse, spi_miso_oe stays 0.
REQ-023 Send 03 00 00 20, raise csb after 3 data bits, then send 03 00 00 40 -> second transfer returns 40 41, no residue from first.
REQ-024 Send opcode 0x5A -> cmd_err pulses once, MISO stays 0, next 03 command behaves normally.
REQ-025 Assert wb_rst_i mid-DATA with csb low -> all outputs 0 immediately; after release, toggling sclk without a new csb fall produces no output.
